// File: rtl/net_phase_cal.sv
// ---------------------------------------------------------------------------
// net_phase_cal -- RX sampling-phase calibration.
//
// Scans all RX sampling phases for a fixed window and counts sync hits per
// phase. It then picks the centre of the longest circular run of phases
// that saw enough hits, and locks onto that phase. While locked, it
// watches packet errors and sync loss, and rescans when either goes bad.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : synchronous active-high reset
//   sync_hit      : per-phase sync detect pulses (bit p = phase p)
//   pkt_ok        : good packet on the current phase (pulse)
//   pkt_err       : bad packet on the current phase (pulse)
//   force_rescan  : request a new calibration (pulse)
//   phase_out     : selected phase, drives rx_phase_shift
//   locked        : high while LOCKED
//   scanning      : high while SCAN
//   relock_count  : successful SELECT->LOCKED transitions, saturates at 255
// ---------------------------------------------------------------------------
module net_phase_cal #(
    parameter int PHASES       = 6,
    parameter int DWELL        = 1024,
    parameter int MIN_HITS     = 4,
    parameter int ERR_LIMIT    = 8,
    parameter int LOSS_TIMEOUT = 65536
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PHASES-1:0]         sync_hit,
    input  logic                      pkt_ok,
    input  logic                      pkt_err,
    input  logic                      force_rescan,
    output logic [$clog2(PHASES)-1:0] phase_out,
    output logic                      locked,
    output logic                      scanning,
    output logic [7:0]                relock_count
);

    localparam int PW = $clog2(PHASES);
    localparam int HW = $clog2(DWELL + 1);
    localparam int WW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [WW-1:0] WIN_LAST = WW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_SELECT,
        ST_LOCKED
    } state_t;

    typedef struct packed {
        logic          found;
        logic [PW-1:0] phase;
    } sel_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_clear;
    logic [PHASES-1:0] w_qual;
    sel_t            w_sel;

    logic [WW-1:0]   r_win_cnt;
    logic [EW-1:0]   r_err_cnt;
    logic [EW-1:0]   w_err_next;
    logic            w_err_trip;
    logic [LW-1:0]   r_loss_cnt;
    logic [LW-1:0]   w_loss_next;
    logic            w_loss_trip;

    logic [PW-1:0]   r_phase;
    logic            r_locked;
    logic            r_scanning;
    logic [7:0]      r_relock;

    assign phase_out    = r_phase;
    assign locked       = r_locked;
    assign scanning     = r_scanning;
    assign relock_count = r_relock;

    // Longest circular run of qualifying phases; the lowest start wins ties.
    // The qualify vector is doubled so that a run may wrap past the top phase
    // without any modulo arithmetic.
    function automatic sel_t pick_phase(input logic [PHASES-1:0] qual);
        sel_t                res;
        logic [2*PHASES-1:0] dbl;
        logic [2*PHASES-1:0] tmp;
        logic                run;
        int                  len;
        int                  best_len;
        int                  best_start;
        int                  mid;
        res        = '0;
        dbl        = {qual, qual};
        best_len   = 0;
        best_start = 0;
        for (int s = 0; s < PHASES; s++) begin
            len = 0;
            run = 1'b1;
            for (int k = 0; k < PHASES; k++) begin
                tmp = dbl >> (s + k);
                if (run && tmp[0]) len++;
                else               run = 1'b0;
            end
            if (len > best_len) begin
                best_len   = len;
                best_start = s;
            end
        end
        if (best_len > 0) begin
            mid = best_start + (best_len - 1) / 2;
            if (mid >= PHASES) mid -= PHASES;
            res.found = 1'b1;
            res.phase = PW'(mid);
        end
        return res;
    endfunction

    assign w_sel = pick_phase(w_qual);

    // Error counter: err alone counts up, ok alone clears, both together hold.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_err_next = r_err_cnt;
        if (pkt_err && !pkt_ok && (r_err_cnt != '1)) w_err_next = r_err_cnt + EW'(1);
        else if (pkt_ok && !pkt_err)                 w_err_next = '0;
    end

    assign w_err_trip  = (w_err_next >= EW'(ERR_LIMIT));
    assign w_loss_next = sync_hit[r_phase] ? '0 :
                         ((r_loss_cnt != '1) ? r_loss_cnt + LW'(1) : r_loss_cnt);
    assign w_loss_trip = (w_loss_next >= LW'(LOSS_TIMEOUT));

    // Next-state logic; force_rescan overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SCAN:   if (r_win_cnt == WIN_LAST) w_state_next = ST_SELECT;
            ST_SELECT: w_state_next = w_sel.found ? ST_LOCKED : ST_SCAN;
            ST_LOCKED: if (w_err_trip || w_loss_trip) w_state_next = ST_SCAN;
            default:   w_state_next = ST_SCAN;
        endcase
        if (force_rescan) w_state_next = ST_SCAN;
    end

    // Entering SCAN, including a forced restart while already scanning.
    assign w_clear = (w_state_next == ST_SCAN) && ((r_state != ST_SCAN) || force_rescan);

    // Per-phase hit counters and qualification.
    for (genvar g = 0; g < PHASES; g++) begin : g_hit
        logic [HW-1:0] r_hit_cnt;

        // NOTE: these counters sit in a per-phase array but are ordinary
        // flops, so they are cleared by reset along with the rest of the state.
        always_ff @(posedge clk) begin
            if (rst || w_clear) begin
                r_hit_cnt <= '0;
            end else if ((r_state == ST_SCAN) && sync_hit[g] && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + HW'(1);
            end
        end

        assign w_qual[g] = (r_hit_cnt >= HW'(MIN_HITS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SCAN;
            r_win_cnt  <= '0;
            r_err_cnt  <= '0;
            r_loss_cnt <= '0;
            r_phase    <= '0;
            r_locked   <= 1'b0;
            r_scanning <= 1'b1;
            r_relock   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            r_state    <= w_state_next;
            r_locked   <= (w_state_next == ST_LOCKED);
            r_scanning <= (w_state_next == ST_SCAN);
            if (w_clear) begin
                r_win_cnt  <= '0;
                r_err_cnt  <= '0;
                r_loss_cnt <= '0;
            end else begin
                case (r_state)
                    ST_SCAN: begin
                        if (r_win_cnt != WIN_LAST) r_win_cnt <= r_win_cnt + WW'(1);
                    end
                    ST_SELECT: begin
                        // Only reached with a qualifying run; the empty case
                        // goes back to SCAN through w_clear.
                        r_phase <= w_sel.phase;
                        if (r_relock != 8'hFF) r_relock <= r_relock + 8'd1;
                    end
                    ST_LOCKED: begin
                        r_err_cnt  <= w_err_next;
                        r_loss_cnt <= w_loss_next;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_net_phase_cal.sv
// ---------------------------------------------------------------------------
// tb_net_phase_cal -- self-checking bench for net_phase_cal.
// A behavioural model tracks state from the calibration rules each cycle;
// directed scenarios add fixed expectations on the documented corner cases.
// ---------------------------------------------------------------------------
module tb_net_phase_cal;

    localparam int PHASES       = 6;
    localparam int DWELL        = 16;
    localparam int MIN_HITS     = 4;
    localparam int ERR_LIMIT    = 3;
    localparam int LOSS_TIMEOUT = 32;

    localparam int M_SCAN   = 0;
    localparam int M_SELECT = 1;
    localparam int M_LOCKED = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PHASES-1:0] sync_hit = '0;
    logic              pkt_ok = 1'b0;
    logic              pkt_err = 1'b0;
    logic              force_rescan = 1'b0;
    logic [2:0]        phase_out;
    logic              locked;
    logic              scanning;
    logic [7:0]        relock_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_state;
    int m_hits [PHASES];
    int m_win;
    int m_err;
    int m_loss;
    int m_phase;
    int m_relock;

    net_phase_cal #(
        .PHASES      (PHASES),
        .DWELL       (DWELL),
        .MIN_HITS    (MIN_HITS),
        .ERR_LIMIT   (ERR_LIMIT),
        .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_hit    (sync_hit),
        .pkt_ok      (pkt_ok),
        .pkt_err     (pkt_err),
        .force_rescan(force_rescan),
        .phase_out   (phase_out),
        .locked      (locked),
        .scanning    (scanning),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit hit_on(input int p);
        logic [PHASES-1:0] tmp;
        tmp = sync_hit >> p;
        return tmp[0];
    endfunction

    task automatic model_clear();
        m_state = M_SCAN;
        m_win   = 0;
        m_err   = 0;
        m_loss  = 0;
        for (int p = 0; p < PHASES; p++) m_hits[p] = 0;
    endtask

    // Longest run (wrapping) of qualifying phases, lowest start among equals.
    function automatic int longest_run(output int start);
        bit all_q;
        for (int len = PHASES; len >= 1; len--) begin
            for (int s = 0; s < PHASES; s++) begin
                all_q = 1'b1;
                for (int k = 0; k < len; k++)
                    if (m_hits[(s + k) % PHASES] < MIN_HITS) all_q = 1'b0;
                if (all_q) begin
                    start = s;
                    return len;
                end
            end
        end
        start = 0;
        return 0;
    endfunction

    task automatic model_step();
        int st;
        int len;
        if (rst) begin
            m_phase  = 0;
            m_relock = 0;
            model_clear();
            return;
        end
        if (force_rescan) begin
            model_clear();
            return;
        end
        case (m_state)
            M_SCAN: begin
                for (int p = 0; p < PHASES; p++) if (hit_on(p)) m_hits[p]++;
                m_win++;
                if (m_win == DWELL) m_state = M_SELECT;
            end
            M_SELECT: begin
                len = longest_run(st);
                if (len == 0) begin
                    model_clear();
                end else begin
                    m_phase = (st + (len - 1) / 2) % PHASES;
                    if (m_relock < 255) m_relock++;
                    m_state = M_LOCKED;
                end
            end
            default: begin
                if (pkt_err && !pkt_ok)      m_err++;
                else if (pkt_ok && !pkt_err) m_err = 0;
                if (hit_on(m_phase)) m_loss = 0;
                else                 m_loss++;
                if (m_err >= ERR_LIMIT || m_loss >= LOSS_TIMEOUT) model_clear();
            end
        endcase
    endtask

    // One clock: inputs held across the edge, model advanced, outputs compared.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check("locked",   locked,       (m_state == M_LOCKED) ? 1 : 0);
        check("scanning", scanning,     (m_state == M_SCAN) ? 1 : 0);
        check("phase",    phase_out,    m_phase);
        check("relock",   relock_count, m_relock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with rst low).
    task automatic do_reset();
        rst          = 1'b1;
        sync_hit     = '0;
        pkt_ok       = 1'b0;
        pkt_err      = 1'b0;
        force_rescan = 1'b0;
        run(2);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic ok, input logic err);
        pkt_ok  = ok;
        pkt_err = err;
        cycle();
        pkt_ok  = 1'b0;
        pkt_err = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_phase",    phase_out,    0);
        check("rst_locked",   locked,       0);
        check("rst_scanning", scanning,     1);
        check("rst_relock",   relock_count, 0);

        // Phases 1..3 hit: centre is 2, lock from cycle 17
        sync_hit = 6'b001110;
        run(16);
        check("c16_locked", locked,   0);
        check("c16_scan",   scanning, 0);
        run(1);
        check("c17_locked", locked,       1);
        check("c17_phase",  phase_out,    2);
        check("c17_relock", relock_count, 1);

        // Wrap-around run 5,0,1 selects 0
        do_reset();
        sync_hit = 6'b100011;
        run(17);
        check("wrap_phase",  phase_out, 0);
        check("wrap_locked", locked,    1);

        // All phases qualify selects 2
        do_reset();
        sync_hit = 6'b111111;
        run(17);
        check("all_phase", phase_out, 2);

        // No hits: back to scanning
        do_reset();
        run(17);
        check("none_scan",   scanning,     1);
        check("none_locked", locked,       0);
        check("none_relock", relock_count, 0);

        // Three hits per phase: one short of qualifying
        do_reset();
        sync_hit = 6'b111111;
        run(3);
        sync_hit = '0;
        run(14);
        check("three_scan",   scanning,     1);
        check("three_locked", locked,       0);
        check("three_relock", relock_count, 0);

        // Exactly MIN_HITS using the first and last window cycles
        do_reset();
        sync_hit = 6'b111111;
        run(1);
        sync_hit = '0;
        run(12);
        sync_hit = 6'b111111;
        run(3);
        sync_hit = '0;
        run(1);
        check("edge_locked", locked,    1);
        check("edge_phase",  phase_out, 2);

        // Error counting: err,err,ok,err,err,(ok+err),err
        do_reset();
        sync_hit = 6'b001110;
        run(17);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check("err2_locked", locked, 1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check("err_after_ok_locked", locked, 1);
        pulse(1'b1, 1'b1);
        check("both_locked", locked, 1);
        pulse(1'b0, 1'b1);
        check("err_limit_scan", scanning,  1);
        check("err_limit_phase", phase_out, 2);

        // Sync loss on the locked phase
        do_reset();
        sync_hit = 6'b001110;
        run(17);
        sync_hit = '0;
        run(31);
        check("loss31_locked", locked, 1);
        run(1);
        check("loss32_scan",  scanning,  1);
        check("loss32_phase", phase_out, 2);

        // force_rescan during SELECT
        do_reset();
        sync_hit = 6'b001110;
        run(16);
        force_rescan = 1'b1;
        cycle();
        force_rescan = 1'b0;
        check("fsel_scan",   scanning,     1);
        check("fsel_relock", relock_count, 0);
        check("fsel_phase",  phase_out,    0);
        run(17);
        check("fsel_relocked", locked,       1);
        check("fsel_relock1",  relock_count, 1);

        // Error limit and force in the same cycle, then a fresh full window
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        force_rescan = 1'b1;
        pulse(1'b0, 1'b1);
        force_rescan = 1'b0;
        check("ferr_scan", scanning, 1);
        run(16);
        check("ferr_select", scanning, 0);
        run(1);
        check("ferr_locked", locked,       1);
        check("ferr_relock", relock_count, 2);

        // rst during LOCKED overrides force_rescan and packet inputs
        rst          = 1'b1;
        force_rescan = 1'b1;
        pkt_err      = 1'b1;
        cycle();
        check("rstl_phase",    phase_out,    0);
        check("rstl_locked",   locked,       0);
        check("rstl_scanning", scanning,     1);
        check("rstl_relock",   relock_count, 0);
        rst          = 1'b0;
        force_rescan = 1'b0;
        pkt_err      = 1'b0;

        // relock_count saturation
        do_reset();
        sync_hit = 6'b111111;
        run(17);
        for (int i = 0; i < 258; i++) begin
            force_rescan = 1'b1;
            cycle();
            force_rescan = 1'b0;
            run(17);
        end
        check("relock_sat", relock_count, 255);

        // Randomized traffic against the model
        do_reset();
        for (int r = 0; r < 40; r++) begin
            logic [PHASES-1:0] mask;
            mask = PHASES'($urandom);
            for (int c = 0; c < 60; c++) begin
                sync_hit     = mask & PHASES'($urandom | $urandom);
                pkt_err      = ($urandom_range(0, 5) == 0);
                pkt_ok       = ($urandom_range(0, 5) == 0);
                force_rescan = ($urandom_range(0, 79) == 0);
                rst          = ($urandom_range(0, 299) == 0);
                cycle();
            end
        end
        rst          = 1'b0;
        force_rescan = 1'b0;
        pkt_ok       = 1'b0;
        pkt_err      = 1'b0;
        sync_hit     = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
